// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: key/voice counts and the
// per-voice state record used by the allocator and its selector.
package synth_pkg;

  localparam int NUM_KEYS   = 88;
  localparam int KEY_W      = 7;
  localparam int NUM_VOICES = 8;
  localparam int AGE_W      = 16;
  // Release counter width; holds release tails up to 8191 cycles.
  localparam int REL_W      = 13;
  localparam int VIDX_W     = $clog2(NUM_VOICES);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             gate;
    logic             active;
    logic [AGE_W-1:0] age;
    logic [REL_W-1:0] rel_cnt;
  } voice_t;

endpackage

// File: rtl/voice_select.sv
// Combinational voice chooser for a new key press: retrigger a releasing
// voice already on this key, else the lowest free voice, else the oldest
// releasing voice, else steal the oldest gated voice.
module voice_select
  import synth_pkg::*;
(
  input  voice_t            i_voices [NUM_VOICES],
  input  logic [KEY_W-1:0]  i_key,
  output logic [VIDX_W-1:0] o_sel,
  output logic              o_steal
);

  logic              w_retrig_hit, w_free_hit, w_rel_hit;
  logic [VIDX_W-1:0] w_retrig_idx, w_free_idx, w_rel_idx, w_old_idx;
  logic [AGE_W-1:0]  w_rel_age, w_old_age;

  // Scan all voices once per category, then apply the fixed priority.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_retrig_hit = 1'b0;
    w_retrig_idx = '0;
    w_free_hit   = 1'b0;
    w_free_idx   = '0;
    w_rel_hit    = 1'b0;
    w_rel_idx    = '0;
    w_rel_age    = '0;
    w_old_idx    = '0;
    w_old_age    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!w_retrig_hit && i_voices[v].active && !i_voices[v].gate &&
          i_voices[v].key == i_key) begin
        w_retrig_hit = 1'b1;
        w_retrig_idx = VIDX_W'(v);
      end
      if (!w_free_hit && !i_voices[v].active) begin
        w_free_hit = 1'b1;
        w_free_idx = VIDX_W'(v);
      end
      // Strict greater-than keeps the lowest index on equal ages.
      if (i_voices[v].active && !i_voices[v].gate &&
          (!w_rel_hit || i_voices[v].age > w_rel_age)) begin
        w_rel_hit = 1'b1;
        w_rel_idx = VIDX_W'(v);
        w_rel_age = i_voices[v].age;
      end
      if (i_voices[v].gate && (v == 0 || i_voices[v].age > w_old_age)) begin
        w_old_idx = VIDX_W'(v);
        w_old_age = i_voices[v].age;
      end
    end

    o_steal = 1'b0;
    if (w_retrig_hit) begin
      o_sel = w_retrig_idx;
    end else if (w_free_hit) begin
      o_sel = w_free_idx;
    end else if (w_rel_hit) begin
      o_sel = w_rel_idx;
    end else begin
      o_sel   = w_old_idx;
      o_steal = 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans the key-state vector one key per cycle,
// turns presses into voice allocations and releases into release tails.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int REL_CYCLES = 4800
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         keys_in,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic                        voice_stolen,
  output logic                        scan_wrap
);

  localparam logic [REL_W-1:0] REL_LOAD = REL_W'(REL_CYCLES);

  logic [NUM_KEYS-1:0]   r_keys_q;
  logic [NUM_KEYS-1:0]   r_prev;
  logic [KEY_W-1:0]      r_idx;
  voice_t                r_voice [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_trig;
  logic                  r_stolen;
  logic                  r_scan_wrap;

  logic                  w_key_now, w_key_prev, w_rise, w_fall;
  logic [VIDX_W-1:0]     w_sel, w_off_idx;
  logic                  w_steal, w_off_hit;

  assign w_key_now  = r_keys_q[r_idx];
  assign w_key_prev = r_prev[r_idx];
  assign w_rise     = w_key_now & ~w_key_prev;
  assign w_fall     = ~w_key_now & w_key_prev;

  voice_select u_voice_select (
    .i_voices (r_voice),
    .i_key    (r_idx),
    .o_sel    (w_sel),
    .o_steal  (w_steal)
  );

  // Find the gated voice holding the key being scanned, for note-off.
  always_comb begin
    w_off_hit = 1'b0;
    w_off_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!w_off_hit && r_voice[v].gate && r_voice[v].key == r_idx) begin
        w_off_hit = 1'b1;
        w_off_idx = VIDX_W'(v);
      end
    end
  end

  // Key sampling and the free-running scan pointer with per-key history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the key history is cleared on reset so held keys are seen again as presses.
      r_keys_q    <= '0;
      r_prev      <= '0;
      r_idx       <= '0;
      r_scan_wrap <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_keys_q      <= keys_in;
      r_prev[r_idx] <= w_key_now;
      r_idx         <= (r_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : r_idx + 1'b1;
      r_scan_wrap   <= (r_idx == KEY_W'(NUM_KEYS - 1));
    end
  end

  // Per-voice state: allocation beats note-off beats ageing and tail expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) r_voice[v] <= '0;
      r_trig   <= '0;
      r_stolen <= 1'b0;
    end else begin
      r_trig   <= '0;
      r_stolen <= w_rise & w_steal;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_rise && w_sel == VIDX_W'(v)) begin
          r_voice[v].key     <= r_idx;
          r_voice[v].gate    <= 1'b1;
          r_voice[v].active  <= 1'b1;
          r_voice[v].age     <= '0;
          r_voice[v].rel_cnt <= '0;
          r_trig[v]          <= 1'b1;
        end else if (w_fall && w_off_hit && w_off_idx == VIDX_W'(v)) begin
          r_voice[v].gate <= 1'b0;
          r_voice[v].age  <= '0;
          if (REL_CYCLES == 0) begin
            r_voice[v].active  <= 1'b0;
            r_voice[v].rel_cnt <= '0;
          end else begin
            r_voice[v].rel_cnt <= REL_LOAD;
          end
        end else begin
          if (r_voice[v].active && r_voice[v].age != '1)
            r_voice[v].age <= r_voice[v].age + 1'b1;
          if (r_voice[v].active && !r_voice[v].gate) begin
            // Counter reaching zero on this edge ends the tail exactly REL_CYCLES after note-off.
            if (r_voice[v].rel_cnt <= REL_W'(1)) begin
              r_voice[v].active  <= 1'b0;
              r_voice[v].rel_cnt <= '0;
            end else begin
              r_voice[v].rel_cnt <= r_voice[v].rel_cnt - 1'b1;
            end
          end
        end
      end
    end
  end

  // Flatten voice state onto the voice-bank outputs.
  always_comb begin
    voice_key    = '0;
    voice_gate   = '0;
    voice_active = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KEY_W +: KEY_W] = r_voice[v].key;
      voice_gate[v]               = r_voice[v].gate;
      voice_active[v]             = r_voice[v].active;
    end
  end

  assign voice_trig   = r_trig;
  assign voice_stolen = r_stolen;
  assign scan_wrap    = r_scan_wrap;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: expected voice events are queued as
// keys are driven and matched against trig / gate-off events seen on the DUT.
module tb_voice_allocator;
  import synth_pkg::*;

  localparam int REL     = 200;
  localparam int EV_TRIG = 0;
  localparam int EV_OFF  = 1;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_KEYS-1:0]         keys_in;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       voice_gate, voice_active, voice_trig;
  logic                        voice_stolen, scan_wrap;

  typedef struct {
    int kind;
    int voice;
    int key;
    int stolen;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;
  int  stolen_cnt = 0;
  int  free_cnt = 0;
  int  off_cyc  [NUM_VOICES];
  int  free_cyc [NUM_VOICES];
  int  trig_cyc [NUM_VOICES];
  logic [NUM_VOICES-1:0] prev_gate, prev_act, prev_trig;

  voice_allocator #(.REL_CYCLES(REL)) dut (
    .clk          (clk),
    .reset        (reset),
    .keys_in      (keys_in),
    .voice_key    (voice_key),
    .voice_gate   (voice_gate),
    .voice_active (voice_active),
    .voice_trig   (voice_trig),
    .voice_stolen (voice_stolen),
    .scan_wrap    (scan_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int voice, input int key, input int stolen);
    ev_t e;
    e.kind = kind; e.voice = voice; e.key = key; e.stolen = stolen;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare(input int kind, input int voice, input int key, input int stolen);
    ev_t e;
    check("ev_pending", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_voice", voice, e.voice);
      check("ev_key", key, e.key);
      check("ev_stolen", stolen, e.stolen);
    end
  endtask

  // Event monitor: one trig or gate-off per voice per cycle, frees logged.
  always @(negedge clk) begin
    if (reset) begin
      prev_gate = '0;
      prev_act  = '0;
      prev_trig = '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_trig[v]) begin
          check("trig_width", int'(prev_trig[v]), 0);
          trig_cyc[v] = cyc;
          pop_compare(EV_TRIG, v, int'(voice_key[v*KEY_W +: KEY_W]), int'(voice_stolen));
        end else if (prev_gate[v] && !voice_gate[v]) begin
          off_cyc[v] = cyc;
          pop_compare(EV_OFF, v, int'(voice_key[v*KEY_W +: KEY_W]), 0);
        end
        if (prev_act[v] && !voice_active[v]) begin
          free_cyc[v] = cyc;
          free_cnt++;
        end
      end
      if (voice_stolen) stolen_cnt++;
      prev_gate = voice_gate;
      prev_act  = voice_active;
      prev_trig = voice_trig;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Park the scan pointer near key 20 so low keys are scanned in order next.
  task automatic sync_scan();
    int n = 0;
    while (!scan_wrap && n < 100) begin
      tick();
      n++;
    end
    check("wrap_seen", int'(scan_wrap), 1);
    repeat (20) tick();
  endtask

  initial begin
    int nz, wraps, first_wrap, last_wrap, t0, exp_c, n, free_before;

    reset   = 1'b1;
    keys_in = '0;
    repeat (3) @(posedge clk);
    tick();
    check("rst_key", int'(|voice_key), 0);
    check("rst_gate", int'(voice_gate), 0);
    check("rst_active", int'(voice_active), 0);
    check("rst_pulses", int'({voice_trig, voice_stolen, scan_wrap}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle scanning: no voice activity, wrap pulse every NUM_KEYS cycles.
    nz = 0; wraps = 0; first_wrap = -1; last_wrap = -1;
    repeat (200) begin
      @(negedge clk);
      if (|{voice_key, voice_gate, voice_active, voice_trig, voice_stolen}) nz++;
      if (scan_wrap) begin
        if (first_wrap < 0) first_wrap = cyc;
        else check("wrap_period", cyc - last_wrap, NUM_KEYS);
        last_wrap = cyc;
        wraps++;
      end
    end
    #1;
    check("idle_nonzero", nz, 0);
    check("first_wrap_cyc", first_wrap, NUM_KEYS);
    check("wrap_count", wraps, 2);

    // Single key: edge at scan slot of key 40 after keys_q has the press.
    push_ev(EV_TRIG, 0, 40, 0);
    keys_in[40] = 1'b1;
    t0 = cyc;
    wait_drain(120, "press40");
    exp_c = t0 + 2;
    while ((exp_c - 1) % NUM_KEYS != 40) exp_c++;
    check("press40_cycle", trig_cyc[0], exp_c);
    check("press40_key", int'(voice_key[KEY_W-1:0]), 40);
    check("press40_gate", int'(voice_gate), 1);
    check("press40_active", int'(voice_active), 1);

    push_ev(EV_OFF, 0, 40, 0);
    keys_in[40] = 1'b0;
    wait_drain(120, "rel40");
    check("rel40_tail_active", int'(voice_active[0]), 1);
    n = 0;
    while (voice_active[0] && n < REL + 50) begin
      tick();
      n++;
    end
    check("rel40_freed", int'(voice_active[0]), 0);
    check("rel40_tail_len", free_cyc[0] - off_cyc[0], REL);

    // Nine keys on eight voices: key 8 steals voice 0, the oldest.
    sync_scan();
    for (int k = 0; k < NUM_VOICES; k++) push_ev(EV_TRIG, k, k, 0);
    push_ev(EV_TRIG, 0, 8, 1);
    keys_in[8:0] = '1;
    wait_drain(200, "press9");
    check("steal_key", int'(voice_key[KEY_W-1:0]), 8);
    check("steal_gates", int'(voice_gate), 8'hFF);
    check("steal_count", stolen_cnt, 1);

    // Releasing the stolen key must leave every voice alone.
    keys_in[0] = 1'b0;
    repeat (2 * NUM_KEYS) tick();
    check("stolen_rel_gates", int'(voice_gate), 8'hFF);
    check("stolen_rel_key", int'(voice_key[KEY_W-1:0]), 8);

    // Release and re-press key 5 inside its tail: same voice, no steal.
    free_before = free_cnt;
    push_ev(EV_OFF, 5, 5, 0);
    keys_in[5] = 1'b0;
    wait_drain(120, "rel5");
    push_ev(EV_TRIG, 5, 5, 0);
    keys_in[5] = 1'b1;
    wait_drain(120, "repress5");
    check("repress5_no_free", free_cnt - free_before, 0);
    check("repress5_no_steal", stolen_cnt, 1);
    check("repress5_key", int'(voice_key[5*KEY_W +: KEY_W]), 5);

    // Three voices releasing, then reset: held keys 4..8 re-detected.
    sync_scan();
    for (int k = 1; k <= 3; k++) push_ev(EV_OFF, k, k, 0);
    keys_in[3:1] = '0;
    wait_drain(200, "rel123");
    check("rel123_active", int'(voice_active[3:1]), 3'b111);
    check("rel123_gate", int'(voice_gate[3:1]), 0);
    reset = 1'b1;
    tick();
    check("midrel_rst_active", int'(voice_active), 0);
    check("midrel_rst_gate", int'(voice_gate), 0);
    check("midrel_rst_key", int'(|voice_key), 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) push_ev(EV_TRIG, k, k + 4, 0);
    wait_drain(200, "post_rst");
    check("post_rst_active", int'(voice_active), 8'h1F);
    check("post_rst_gate", int'(voice_gate), 8'h1F);
    check("total_steals", stolen_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
